// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a valid/ready byte stream.
// Stream format: one length byte N (0 means 2^ADDR_W words), followed by N
// big-endian 16-bit opcodes. Each opcode becomes a single-cycle imem write.
// The CPU is held via cpu_hold for the whole load; done pulses at the end.
//
// Optional build macro IMEM_LOADER_CHECKSUM_EN: when defined, a trailing
// byte must equal the XOR of every byte accepted before it. A mismatch sets
// the sticky err flag and leaves the CPU held until a new start.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int OP_W   = 16  // two stream bytes per opcode; only 16 is meaningful
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OP_W-1:0]   wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HI,
    S_LO,
    S_WR,
    S_CHK,
    S_FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  // Address of the final word; header N maps to N-1 modulo 2^ADDR_W, so a
  // header of 0 naturally selects the full memory depth.
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] hdr_cnt;
  logic [7:0]        hi_byte;
  logic              accept;
  logic              start_ok;
  logic              at_last;

  assign accept   = in_valid & in_ready;
  assign start_ok = (state == S_IDLE) & start;
  assign hdr_cnt  = ADDR_W'(in_data);
  assign at_last  = (wr_addr == last_addr);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_match;

  assign csum_match = (in_data == csum);

  // Running XOR of header and opcode bytes; err latches a trailer mismatch
  // and stays set until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'h00;
      err  <= 1'b0;
    end else if (start_ok) begin
      csum <= 8'h00;
      err  <= 1'b0;
    end else if (accept && (state == S_CHK)) begin
      if (!csum_match) begin
        err <= 1'b1;
      end
    end else if (accept) begin
      csum <= csum ^ in_data;
    end
  end
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; byte-consuming states advance only on a handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (accept) begin
          state_nxt = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (at_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_FIN;
`endif
        end else begin
          state_nxt = S_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_nxt = csum_match ? S_FIN : S_IDLE;
        end
      end
`endif
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered control outputs, derived from the state being entered so
  // they line up with that state's cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b0;
    end else begin
      in_ready <= (state_nxt == S_HDR) | (state_nxt == S_HI) |
                  (state_nxt == S_LO)  | (state_nxt == S_CHK);
      wr_en    <= (state_nxt == S_WR);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_FIN);
      // A failed checksum returns to IDLE without passing FIN, so the CPU
      // stays held until a successful reload.
      if (start_ok) begin
        cpu_hold <= 1'b1;
      end else if (state == S_FIN) begin
        cpu_hold <= 1'b0;
      end
    end
  end

  // Address, header and opcode assembly registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      wr_data   <= '0;
      hi_byte   <= 8'h00;
      last_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            wr_addr <= '0;
          end
        end
        S_HDR: begin
          if (accept) begin
            last_addr <= hdr_cnt - ADDR_W'(1);
          end
        end
        S_HI: begin
          if (accept) begin
            hi_byte <= in_data;
          end
        end
        S_LO: begin
          if (accept) begin
            wr_data <= OP_W'({hi_byte, in_data});
          end
        end
        S_WR: begin
          // The final address is left in place; it is cleared by the next start.
          if (!at_last) begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The CPU core only reads imem (pc -> op); this block fills imem from an external byte stream.
- Accepts a length header followed by big-endian 16-bit opcodes over a valid/ready byte interface and issues one imem write per opcode.
- Holds the CPU (pc write and register/memory writes gated by cpu_hold at top level) for the whole load, then pulses done.

Parameters:
- ADDR_W, 6, imem address width; must match pc width.
- OP_W, 16, opcode width; fixed at 2 bytes, so only 16 is legal.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a load; ignored unless in IDLE
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both 1
- wr_en  output  1  imem write strobe, one cycle per opcode
- wr_addr  output  ADDR_W  imem write address
- wr_data  output  OP_W  opcode to write
- cpu_hold  output  1  high from start acceptance until load ends; CPU must not advance
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse on successful completion
- err  output  1  sticky checksum error (CHECKSUM_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, err=0; internal count/hi-byte registers cleared. Reset mid-load abandons the load immediately; imem keeps any words already written.
- All outputs are registered.
- IDLE: in_ready=0. When start=1: next state HDR; cpu_hold=1, busy=1, wr_addr=0; err cleared.
- HDR: in_ready=1. Accepted byte = word count N. N=0 means 2^ADDR_W (64). Next state HI.
- HI: in_ready=1. Accepted byte latched as op[15:8]. Next state LO.
- LO: in_ready=1. Accepted byte forms op[7:0]. Next state WR. wr_data={hi,byte} is registered on this edge.
- WR: in_ready=0, wr_en=1 for exactly this cycle with current wr_addr and wr_data.
  - If wr_addr == N-1 (modulo 2^ADDR_W), next state is CHK when CHECKSUM_EN is defined, else FIN.
  - Otherwise wr_addr increments by 1 and next state is HI.
- FIN: done=1 for one cycle; cpu_hold and busy fall on the next edge; next state IDLE. wr_addr holds its last value until the next start.
- Bytes with in_valid=0 stall any state indefinitely; there is no timeout.
- in_ready is 0 in IDLE, WR and FIN; valid bytes offered then are not consumed.
- start asserted while busy=1 is ignored.
- wr_addr wraps naturally. A 64-word load ends with the write at address 63 and never writes address 0 twice.
- Throughput: 3 cycles per opcode with in_valid held high (HI, LO, WR).
- Minimum load latency: start-to-done = 1 + 1 + 3N + 1 cycles (checksum adds 1).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted byte (header and all opcode bytes) is kept, starting at 0.
  - State CHK (in_ready=1) accepts one trailing byte.
  - If it equals the running XOR: go FIN as normal.
  - On mismatch: err=1 (sticky until next start), no done pulse, cpu_hold stays 1, state returns to IDLE with busy=0. A new start is required to retry.
- Undefined: no CHK state, no trailing byte expected, err tied 0.

Test Plan:
- Reset: drive rst_n=0 mid-load after 2 opcodes -> all outputs 0 asynchronously, state IDLE, in_ready=0 next cycle after release.
- Basic load: start, stream 0x02,0x12,0x34,0xAB,0xCD with in_valid always 1 -> writes (addr0,0x1234) then (addr1,0xABCD). Each wr_en is exactly 1 cycle. done pulses once; cpu_hold high from the cycle after start until the cycle after done.
- Backpressure/gaps: same stream with in_valid toggled 1-0-1 randomly -> identical writes and data. No byte is consumed while in_ready=0; a byte held during WR is taken in the next HI.
- Full depth: header 0x00 then 64 opcodes 0x0000..0x003F -> 64 writes, wr_addr 0..63, last write addr 63 = 0x003F, done after it; no write to addr 0 after the first.
- Ignored start: pulse start during HI -> no restart, wr_addr continues, result unchanged.
- Checksum (macro defined): stream 0x01,0x12,0x34 with trailer 0x27 -> done=1, err=0. Repeat with trailer 0x00 -> err=1, no done, cpu_hold stays 1, busy=0. A new start clears err.
